// File: rtl/i2s_rx_slave.sv
// I2S slave receiver: oversamples async SCK/WS/SD in the clk_i domain, deserialises
// Philips-format MSB-first slots and presents {left,right} pairs on a valid/ready port.
module i2s_rx_slave #(
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned SLOT_WIDTH   = 32,
  parameter logic        WS_POL       = 1'b0,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    sck_i,
  input  logic                    ws_i,
  input  logic                    sd_i,
  output logic [SAMPLE_WIDTH-1:0] sample_l_o,
  output logic [SAMPLE_WIDTH-1:0] sample_r_o,
  output logic                    sample_valid_o,
  input  logic                    sample_ready_i,
  output logic                    overrun_o,
  output logic                    frame_err_o
);

  // Counter must hold the saturation value plus the boundary bit.
  localparam int unsigned CNT_W = $clog2(SLOT_WIDTH + 3);
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_WIDTH);
  localparam logic [CNT_W-1:0] SLOT_CNT   = CNT_W'(SLOT_WIDTH);
  localparam logic [CNT_W-1:0] SAT_CNT    = CNT_W'(SLOT_WIDTH + 1);

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_e;

  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  logic [SYNC_STAGES-1:0] sck_sync_q, ws_sync_q, sd_sync_q;
  logic                   sck_prev_q;
  logic                   sck_s, ws_s, sd_s, rise;

  // Identical chains keep SCK, WS and SD mutually aligned.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q <= '0;
      ws_sync_q  <= '0;
      sd_sync_q  <= '0;
      sck_prev_q <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      ws_sync_q  <= {ws_sync_q[SYNC_STAGES-2:0], ws_i};
      sd_sync_q  <= {sd_sync_q[SYNC_STAGES-2:0], sd_i};
      sck_prev_q <= sck_s;
    end
  end

  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign ws_s  = ws_sync_q[SYNC_STAGES-1];
  assign sd_s  = sd_sync_q[SYNC_STAGES-1];
  assign rise  = sck_s & ~sck_prev_q;

  state_e                  state_q, state_d;
  logic                    ws_last_q, ws_last_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                    have_left_q, have_left_d;
  logic [SAMPLE_WIDTH-1:0] sample_l_q, sample_l_d;
  logic [SAMPLE_WIDTH-1:0] sample_r_q, sample_r_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic                    frame_err_q, frame_err_d;

  logic [SAMPLE_WIDTH-1:0] shift_in, slot_sample;
  logic [CNT_W-1:0]        slot_len;
  logic                    pair_load;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_UNLOCKED;
      ws_last_q   <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      have_left_q <= 1'b0;
      sample_l_q  <= '0;
      sample_r_q  <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ws_last_q   <= ws_last_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      have_left_q <= have_left_d;
      sample_l_q  <= sample_l_d;
      sample_r_q  <= sample_r_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state: bit capture on SCK rise, slot close on WS change, output handshake.
  always_comb begin
    state_d     = state_q;
    ws_last_d   = ws_last_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    have_left_d = have_left_q;
    sample_l_d  = sample_l_q;
    sample_r_d  = sample_r_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    pair_load   = 1'b0;

    shift_in = shift_q;
    if (bit_cnt_q < SAMPLE_CNT) shift_in = SAMPLE_WIDTH'({shift_q, sd_s});
    slot_len    = bit_cnt_q + CNT_W'(1);
    slot_sample = (slot_len < SAMPLE_CNT) ? (shift_in << (SAMPLE_CNT - slot_len)) : shift_in;

    if (valid_q && sample_ready_i) valid_d = 1'b0;

    if (rise) begin
      ws_last_d = ws_s;
      if (ws_s != ws_last_q) begin
        bit_cnt_d = '0;
        shift_d   = '0;
        state_d   = ST_LOCKED;
        if (state_q == ST_LOCKED) begin
          frame_err_d = (slot_len != SLOT_CNT);
          if (ws_last_q == WS_POL) begin
            left_hold_d = slot_sample;
            have_left_d = 1'b1;
          end else if (have_left_q) begin
            pair_load = 1'b1;
          end
        end
      end else begin
        shift_d = shift_in;
        if (bit_cnt_q != SAT_CNT) bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end

    if (pair_load) begin
      sample_l_d  = left_hold_q;
      sample_r_d  = slot_sample;
      valid_d     = 1'b1;
      overrun_d   = valid_q & ~sample_ready_i;
      have_left_d = 1'b0;
    end
  end

  assign sample_l_o     = sample_l_q;
  assign sample_r_o     = sample_r_q;
  assign sample_valid_o = valid_q;
  assign overrun_o      = overrun_q;
  assign frame_err_o    = frame_err_q;

endmodule
